// File: rtl/risc_toy_fetch_queue.sv
// RISC_TOY instruction-fetch front end: fetch PC, one-deep in-flight tracker and a
// DEPTH-entry prefetch FIFO feeding decode over a valid/ready handshake.

module risc_toy_fetch_queue_chk #(
    parameter int LW    = 3,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic [LW-1:0] level
);
    // A write into a full FIFO means the issue credit rule has been broken.
    push_on_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (level == LW'(DEPTH))));
endmodule

module risc_toy_fetch_queue #(
    parameter int             AW       = 30,
    parameter int             DW       = 32,
    parameter int             DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    output logic                       IREQ,
    output logic [AW-1:0]              IADDR,
    input  logic [DW-1:0]              INSTR,
    input  logic                       hold_fetch,
    input  logic                       redir_valid,
    input  logic [AW-1:0]              redir_pc,
    output logic                       out_valid,
    output logic [DW-1:0]              out_instr,
    output logic [AW-1:0]              out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] fetch_pc_r;
    logic          in_flight_r;
    logic [AW-1:0] in_flight_pc_r;
    logic [DW-1:0] fifo_instr_r [DEPTH];
    logic [AW-1:0] fifo_pc_r    [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;

    logic          pop_s;
    logic          push_s;
    logic          ireq_s;
    logic [LW:0]   credit_s;

    // Handshake, push qualification and issue credit; a same-cycle pop frees a slot.
    always_comb begin
        pop_s    = 1'b0;
        push_s   = 1'b0;
        credit_s = '0;
        ireq_s   = 1'b0;
        pop_s    = (level_r != '0) & out_ready;
        push_s   = in_flight_r & ~redir_valid;
        credit_s = {1'b0, level_r} + (LW+1)'(in_flight_r) - (LW+1)'(pop_s);
        ireq_s   = RSTN & ~redir_valid & ~hold_fetch & (credit_s < (LW+1)'(DEPTH));
    end

    // Fetch PC and in-flight tracker; a redirect kills the outstanding response.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fetch_pc_r     <= RESET_PC;
            in_flight_r    <= 1'b0;
            in_flight_pc_r <= '0;
        end else if (redir_valid) begin
            fetch_pc_r     <= redir_pc;
            in_flight_r    <= 1'b0;
            in_flight_pc_r <= in_flight_pc_r;
        end else begin
            fetch_pc_r     <= ireq_s ? fetch_pc_r + AW'(1) : fetch_pc_r;
            in_flight_r    <= ireq_s;
            in_flight_pc_r <= fetch_pc_r;
        end
    end

    // FIFO pointers and occupancy; redirect flush wins over push and pop.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (redir_valid) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? rd_ptr_r + PW'(1) : rd_ptr_r;
            level_r  <= level_r + LW'(push_s) - LW'(pop_s);
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_r[i] <= '0;
                fifo_pc_r[i]    <= '0;
            end
        end else if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= INSTR;
            fifo_pc_r[wr_ptr_r]    <= in_flight_pc_r;
        end
    end

    assign IREQ      = ireq_s;
    assign IADDR     = fetch_pc_r;
    assign out_valid = (level_r != '0);
    assign out_instr = fifo_instr_r[rd_ptr_r];
    assign out_pc    = fifo_pc_r[rd_ptr_r];
    assign level     = level_r;

    risc_toy_fetch_queue_chk #(
        .LW    (LW),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (push_s),
        .level (level_r)
    );
endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Randomized bench for risc_toy_fetch_queue against a queue-based reference model.

module tb_risc_toy_fetch_queue;
    localparam int AW    = 30;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam logic [AW-1:0] RPC = 30'h3FFF_FFFE;

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] INSTR;
    logic          hold_fetch;
    logic          redir_valid;
    logic [AW-1:0] redir_pc;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready;
    logic [LW-1:0] level;

    risc_toy_fetch_queue #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
        .hold_fetch(hold_fetch), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .level(level)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] m_fpc;
    logic [AW-1:0] m_ipc;
    bit            m_inf;
    ent_t          m_q[$];
    bit            prev_req;
    logic [AW-1:0] prev_addr;

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return {a, 2'b11} ^ 32'hC3A5_0F00;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_ireq"},  64'(IREQ),      64'd0);
        check_val({tag, "_iaddr"}, 64'(IADDR),     64'(RPC));
        check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_instr"}, 64'(out_instr), 64'd0);
        check_val({tag, "_pc"},    64'(out_pc),    64'd0);
        check_val({tag, "_level"}, 64'(level),     64'd0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inf    = 1'b0;
        m_ipc    = '0;
        m_fpc    = RPC;
        prev_req = 1'b0;
    endtask

    // Compare this cycle's outputs, then advance the model across the edge.
    task automatic step_check();
        bit   exp_valid;
        bit   pop;
        bit   exp_req;
        int   occ;
        ent_t e;
        exp_valid = (m_q.size() != 0);
        pop       = exp_valid && out_ready;
        occ       = int'(m_q.size()) + int'(m_inf) - int'(pop);
        exp_req   = !redir_valid && !hold_fetch && (occ < DEPTH);
        check_val("ireq",  64'(IREQ),      64'(exp_req));
        check_val("iaddr", 64'(IADDR),     64'(m_fpc));
        check_val("valid", 64'(out_valid), 64'(exp_valid));
        check_val("level", 64'(level),     64'(m_q.size()));
        if (exp_valid) begin
            check_val("out_pc",    64'(out_pc),    64'(m_q[0].pc));
            check_val("out_instr", 64'(out_instr), 64'(m_q[0].instr));
        end
        prev_req  = exp_req;
        prev_addr = m_fpc;
        if (redir_valid) begin
            m_q.delete();
            m_inf = 1'b0;
            m_fpc = redir_pc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_inf) begin
                e.instr = instr_of(m_ipc);
                e.pc    = m_ipc;
                m_q.push_back(e);
            end
            m_inf = exp_req;
            m_ipc = m_fpc;
            if (exp_req) m_fpc = m_fpc + 30'd1;
        end
    endtask

    initial begin
        hold_fetch  = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        out_ready   = 1'b0;
        INSTR       = '0;
        RSTN        = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outs("rst");
        model_reset();
        RSTN = 1'b1;
        for (int c = 0; c < 600; c++) begin
            INSTR       = prev_req ? instr_of(prev_addr) : DW'($urandom);
            redir_valid = 1'b0;
            redir_pc    = '0;
            hold_fetch  = 1'b0;
            out_ready   = 1'b1;
            if (c < 40) begin
                out_ready = 1'b1;
            end else if (c < 52) begin
                out_ready = 1'b0;
            end else if (c < 70) begin
                out_ready = 1'b1;
            end else if (c == 70) begin
                redir_valid = 1'b1;
                redir_pc    = 30'h100;
            end else if (c == 71) begin
                redir_valid = 1'b1;
                redir_pc    = 30'h3FFF_FFFF;
            end else if (c >= 395 && c <= 400) begin
                out_ready = 1'b0;
            end else begin
                redir_valid = ($urandom_range(0, 19) == 0);
                redir_pc    = AW'($urandom);
                hold_fetch  = ($urandom_range(0, 3) == 0);
                out_ready   = ($urandom_range(0, 3) != 0);
            end
            if (c == 400) begin
                #1 RSTN = 1'b0;
                #1 check_reset_outs("midrst");
                model_reset();
                @(posedge CLK);
                #1 RSTN = 1'b1;
                INSTR     = DW'($urandom);
                out_ready = 1'b1;
            end
            @(negedge CLK);
            step_check();
            @(posedge CLK);
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
